uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_pkg.sv | 30 +++
 rtl/uart_loader_byte_packer.sv | 34 +++
 rtl/uart_loader.sv | 173 +++++++++++++++++
 tb/tb_uart_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared opcodes, widths, FSM states and response payload for the UART boot loader.
package uart_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned RESP_CNT_W = 3;

    localparam logic [BYTE_W-1:0] OP_WRITE   = 8'hA5;
    localparam logic [BYTE_W-1:0] OP_READ    = 8'hC3;
    localparam logic [BYTE_W-1:0] OP_RELEASE = 8'h0F;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        READ,
        RWAIT,
        TXSEL,
        TXGO,
        TXGAP
    } state_e;

    // Pending response: bytes go out LSB first, left counts what remains
    typedef struct packed {
        logic [RESP_CNT_W-1:0] left;
        logic [WORD_W-1:0]     bytes;
    } resp_t;

endpackage

// File: rtl/uart_loader_byte_packer.sv
// Little-endian 4-byte shift-in: first byte lands in bits [7:0] of the assembled word.
module byte_packer
    import uart_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic [1:0]        cnt,
    output logic              done_c
);

    logic [WORD_W-BYTE_W-1:0] acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt   <= 2'd0;
        end else if (clr) begin
            acc_q <= '0;
            cnt   <= 2'd0;
        end else if (shift_en) begin
            acc_q <= {byte_in, acc_q[WORD_W-BYTE_W-1:BYTE_W]};
            cnt   <= cnt + 2'd1;
        end
    end

    // Word as it will look once the current byte is shifted in
    assign word_c = {byte_in, acc_q};
    assign done_c = shift_en && (cnt == 2'd3);

endmodule

// File: rtl/uart_loader.sv
// UART command loader: host frames drive memory writes/reads and the CPU hold line.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 100_000,
    parameter logic [BYTE_W-1:0] ACK_BYTE       = 8'h5A,
    parameter logic [BYTE_W-1:0] NAK_BYTE       = 8'hEE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_en,
    output logic [BYTE_W-1:0] tx_data,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              cpu_hold
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    resp_t             resp_q, resp_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              is_write_q, is_write_d;
    logic              hold_d, tx_en_d, mem_wen_d, mem_ren_d;
    logic [BYTE_W-1:0] tx_data_d;
    logic [WORD_W-1:0] mem_addr_d, mem_wdata_d;

    logic              pk_shift_c, pk_clr_c, pk_done_c;
    logic [WORD_W-1:0] pk_word_c;
    logic [1:0]        pk_cnt;

    byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pk_clr_c),
        .shift_en (pk_shift_c),
        .byte_in  (rx_data),
        .word_c   (pk_word_c),
        .cnt      (pk_cnt),
        .done_c   (pk_done_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            resp_q     <= '0;
            idle_cnt_q <= '0;
            is_write_q <= 1'b0;
            cpu_hold   <= 1'b1;
            tx_en      <= 1'b0;
            tx_data    <= '0;
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            idle_cnt_q <= idle_cnt_d;
            is_write_q <= is_write_d;
            cpu_hold   <= hold_d;
            tx_en      <= tx_en_d;
            tx_data    <= tx_data_d;
            mem_wen    <= mem_wen_d;
            mem_ren    <= mem_ren_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        idle_cnt_d  = '0;
        is_write_d  = is_write_q;
        hold_d      = cpu_hold;
        tx_en_d     = 1'b0;
        tx_data_d   = tx_data;
        mem_wen_d   = 1'b0;
        mem_ren_d   = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        pk_shift_c  = 1'b0;
        // Keep the packer aligned to a field boundary whenever a frame can start
        pk_clr_c    = (state_q == IDLE) && (pk_cnt != 2'd0);

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_WRITE: begin
                            is_write_d = 1'b1;
                            state_d    = ADDR;
                        end
                        OP_READ: begin
                            is_write_d = 1'b0;
                            state_d    = ADDR;
                        end
                        OP_RELEASE: begin
                            hold_d  = 1'b0;
                            resp_d  = '{left: RESP_CNT_W'(1), bytes: WORD_W'(ACK_BYTE)};
                            state_d = TXSEL;
                        end
                        default: begin
                            resp_d  = '{left: RESP_CNT_W'(1), bytes: WORD_W'(NAK_BYTE)};
                            state_d = TXSEL;
                        end
                    endcase
                end
            end
            ADDR, DATA: begin
                if (rx_valid) begin
                    pk_shift_c = 1'b1;
                    if (pk_done_c) begin
                        if (state_q == ADDR) begin
                            mem_addr_d = pk_word_c;
                            state_d    = is_write_q ? DATA : READ;
                            mem_ren_d  = !is_write_q;
                        end else begin
                            mem_wdata_d = pk_word_c;
                            mem_wen_d   = 1'b1;
                            state_d     = WRITE;
                        end
                    end
                end else if (idle_cnt_q == TO_LAST) begin
                    // Host went quiet mid-frame: drop the partial frame silently
                    pk_clr_c = 1'b1;
                    state_d  = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                resp_d  = '{left: RESP_CNT_W'(1), bytes: WORD_W'(ACK_BYTE)};
                state_d = TXSEL;
            end
            READ: begin
                state_d = RWAIT;
            end
            RWAIT: begin
                resp_d  = '{left: RESP_CNT_W'(4), bytes: mem_rdata};
                state_d = TXSEL;
            end
            TXSEL: begin
                if (!tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = resp_q.bytes[BYTE_W-1:0];
                    state_d   = TXGO;
                end
            end
            TXGO: begin
                resp_d.bytes = resp_q.bytes >> BYTE_W;
                resp_d.left  = resp_q.left - RESP_CNT_W'(1);
                state_d      = TXGAP;
            end
            TXGAP: begin
                // Transmitter may not raise busy until a cycle after tx_en
                state_d = (resp_q.left == '0) ? IDLE : TXSEL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: vector table, randomized frames vs a frame-level model, corner sequences.
module tb_uart_loader;

    localparam int unsigned TO = 16;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          ntx;
        logic [31:0] tx;
        int          nwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nrd;
        bit          hold;
    } exp_t;

    typedef struct {
        logic [71:0] b;
        int          len;
        logic [31:0] rdata;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        cpu_hold;

    int tests = 0;
    int fails = 0;

    logic [7:0]  tx_q[$];
    logic [63:0] wr_q[$];
    logic [31:0] rd_q[$];
    int          busy_viol = 0;
    int          busy_left;
    logic [31:0] rd_val = 32'h0;

    uart_loader #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(8'h5A), .NAK_BYTE(8'hEE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    // Transmitter: busy for a random number of cycles after each tx_en
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             busy_left <= 0;
        else if (tx_en)         busy_left <= $urandom_range(1, 5);
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign tx_busy = (busy_left != 0);

    // Memory: read data only meaningful the cycle after mem_ren
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= rd_val;
        else         mem_rdata <= $urandom();
    end

    always @(negedge clk) begin
        if (tx_en) begin
            tx_q.push_back(tx_data);
            if (tx_busy) busy_viol++;
        end
        if (mem_wen) wr_q.push_back({mem_addr, mem_wdata});
        if (mem_ren) rd_q.push_back(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom());
    endtask

    task automatic send_frame(input bq_t f, input logic [31:0] rdv);
        rd_val = rdv;
        foreach (f[i]) begin
            send_byte(f[i]);
            if (i + 1 < f.size()) idle($urandom_range(0, 3));
        end
    endtask

    // Frame-level reference: what the host should see for one complete or truncated frame
    function automatic exp_t model(input bq_t f, input logic [31:0] rdv, input bit hold_in);
        exp_t e;
        e = '{0, 32'h0, 0, 32'h0, 32'h0, 0, hold_in};
        if (f.size() == 0) return e;
        case (f[0])
            8'hA5: if (f.size() == 9) begin
                e.nwr   = 1;
                e.addr  = {f[4], f[3], f[2], f[1]};
                e.wdata = {f[8], f[7], f[6], f[5]};
                e.ntx   = 1;
                e.tx    = 32'h5A;
            end
            8'hC3: if (f.size() == 5) begin
                e.nrd  = 1;
                e.addr = {f[4], f[3], f[2], f[1]};
                e.ntx  = 4;
                e.tx   = {rdv[7:0], rdv[15:8], rdv[23:16], rdv[31:24]};
            end
            8'h0F: begin
                e.hold = 1'b0;
                e.ntx  = 1;
                e.tx   = 32'h5A;
            end
            default: begin
                e.ntx = 1;
                e.tx  = 32'hEE;
            end
        endcase
        return e;
    endfunction

    task automatic check_frame(input string name, input int tb0, input int wb0, input int rb0, input exp_t e);
        logic [63:0] w;
        logic [7:0]  want;
        check({name, "_ntx"}, 32'(tx_q.size() - tb0), 32'(e.ntx));
        for (int i = 0; i < e.ntx && tb0 + i < tx_q.size(); i++) begin
            want = e.tx[8*(e.ntx-1-i) +: 8];
            check($sformatf("%s_tx%0d", name, i), 32'(tx_q[tb0+i]), 32'(want));
        end
        check({name, "_nwr"}, 32'(wr_q.size() - wb0), 32'(e.nwr));
        if (e.nwr == 1 && wr_q.size() > wb0) begin
            w = wr_q[wb0];
            check({name, "_waddr"}, w[63:32], e.addr);
            check({name, "_wdata"}, w[31:0], e.wdata);
        end
        check({name, "_nrd"}, 32'(rd_q.size() - rb0), 32'(e.nrd));
        if (e.nrd == 1 && rd_q.size() > rb0) check({name, "_raddr"}, rd_q[rb0], e.addr);
        check({name, "_hold"}, 32'(cpu_hold), 32'(e.hold));
        check({name, "_tx_en_while_busy"}, 32'(busy_viol), 32'd0);
    endtask

    task automatic run_and_check(input string name, input bq_t f, input logic [31:0] rdv, input exp_t e);
        int tb0, wb0, rb0;
        tb0 = tx_q.size();
        wb0 = wr_q.size();
        rb0 = rd_q.size();
        send_frame(f, rdv);
        idle(90);
        check_frame(name, tb0, wb0, rb0, e);
    endtask

    function automatic bq_t wr_frame(input logic [31:0] a, input logic [31:0] d);
        bq_t f;
        f = {8'hA5, a[7:0], a[15:8], a[23:16], a[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
        return f;
    endfunction

    function automatic bq_t rd_frame(input logic [31:0] a);
        bq_t f;
        f = {8'hC3, a[7:0], a[15:8], a[23:16], a[31:24]};
        return f;
    endfunction

    vec_t vecs[7];
    bit   hold_m;

    initial begin
        bq_t         f;
        exp_t        e;
        logic [31:0] a, d, r;
        logic [7:0]  j;
        int          tb0, wb0, rb0, seen;
        bit          got;

        rx_valid = 1'b0;
        rx_data  = 8'h00;

        vecs[0] = '{72'hA5_00100000_EFBEADDE, 9, 32'h0,       '{1, 32'h5A,       1, 32'h00001000, 32'hDEADBEEF, 0, 1'b1}};
        vecs[1] = '{72'hC3_00100000,          5, 32'h12345678, '{4, 32'h78563412, 0, 32'h00001000, 32'h0,        1, 1'b1}};
        vecs[2] = '{72'h42,                   1, 32'h0,       '{1, 32'hEE,       0, 32'h0,        32'h0,        0, 1'b1}};
        vecs[3] = '{72'hA5_03000080_01020304, 9, 32'h0,       '{1, 32'h5A,       1, 32'h80000003, 32'h04030201, 0, 1'b1}};
        vecs[4] = '{72'h0F,                   1, 32'h0,       '{1, 32'h5A,       0, 32'h0,        32'h0,        0, 1'b0}};
        vecs[5] = '{72'hA5_00100000_11223344, 9, 32'h0,       '{1, 32'h5A,       1, 32'h00001000, 32'h44332211, 0, 1'b0}};
        vecs[6] = '{72'hFF,                   1, 32'h0,       '{1, 32'hEE,       0, 32'h0,        32'h0,        0, 1'b0}};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_ren", 32'(mem_ren), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 7; v++) begin
            f = {};
            for (int i = 0; i < vecs[v].len; i++) f.push_back(vecs[v].b[8*(vecs[v].len-1-i) +: 8]);
            run_and_check($sformatf("vec%0d", v), f, vecs[v].rdata, vecs[v].e);
        end

        hold_m = 1'b0;
        for (int n = 0; n < 20; n++) begin
            a = $urandom();
            d = $urandom();
            r = $urandom();
            case ($urandom_range(0, 3))
                0: f = wr_frame(a, d);
                1: f = rd_frame(a);
                2: f = {8'h0F};
                default: begin
                    j = 8'($urandom());
                    if (j == 8'hA5 || j == 8'hC3 || j == 8'h0F) j = 8'h42;
                    f = {j};
                end
            endcase
            e = model(f, r, hold_m);
            hold_m = e.hold;
            run_and_check($sformatf("rnd%0d", n), f, r, e);
        end

        // Timeout in ADDR, then a read must execute cleanly
        tb0 = tx_q.size(); wb0 = wr_q.size(); rb0 = rd_q.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
        idle(TO);
        send_frame(rd_frame(32'h00002000), 32'hABCD0123);
        idle(90);
        check_frame("to_addr", tb0, wb0, rb0, model(rd_frame(32'h00002000), 32'hABCD0123, hold_m));

        // Timeout in DATA, then a write must execute cleanly
        tb0 = tx_q.size(); wb0 = wr_q.size(); rb0 = rd_q.size();
        f = wr_frame(32'h00000040, 32'hCAFEF00D);
        for (int i = 0; i < 7; i++) send_byte(f[i]);
        idle(TO);
        send_frame(wr_frame(32'h00000044, 32'h55AA33CC), 32'h0);
        idle(90);
        check_frame("to_data", tb0, wb0, rb0, model(wr_frame(32'h00000044, 32'h55AA33CC), 32'h0, hold_m));

        // Gap of one less than the timeout must not abandon the frame
        tb0 = tx_q.size(); wb0 = wr_q.size(); rb0 = rd_q.size();
        f = wr_frame(32'h00000100, 32'h01234567);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (i == 2) idle(TO - 1);
        end
        idle(90);
        check_frame("to_edge", tb0, wb0, rb0, model(f, 32'h0, hold_m));

        // Bytes arriving while a response is pending are dropped
        tb0 = tx_q.size(); wb0 = wr_q.size(); rb0 = rd_q.size();
        send_frame(rd_frame(32'h00000200), 32'h89ABCDEF);
        send_byte(8'hA5); send_byte(8'h0F); send_byte(8'h42);
        idle(90);
        check_frame("drop", tb0, wb0, rb0, model(rd_frame(32'h00000200), 32'h89ABCDEF, hold_m));

        // Reset while the second readback byte is being sent
        tb0 = tx_q.size(); wb0 = wr_q.size(); rb0 = rd_q.size();
        send_frame(rd_frame(32'h00000300), 32'hA1B2C3D4);
        seen = 0;
        got  = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (tx_en) begin
                seen++;
                if (seen == 2) got = 1'b1;
            end
        end
        check("rst_mid_second_byte_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_mid_hold", 32'(cpu_hold), 32'd1);
        check("rst_mid_tx_en", 32'(tx_en), 32'd0);
        idle(10);
        rst_n = 1'b1;
        idle(40);
        hold_m = 1'b1;
        e = '{2, {16'h0, 8'hD4, 8'hC3}, 0, 32'h00000300, 32'h0, 1, 1'b1};
        check_frame("rst_mid", tb0, wb0, rb0, e);
        run_and_check("post_rst", wr_frame(32'h00000400, 32'h0BADBEEF), 32'h0,
                      model(wr_frame(32'h00000400, 32'h0BADBEEF), 32'h0, hold_m));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
